// File: rtl/cd_frame_seq.sv
// cd_frame_seq: CSR-bus master that sequences a CDBUS controller CSR block.
//   Polls and clears INT_FLAG, drains RX frames from controller RAM into a
//   byte stream, and writes TX byte-stream frames into TX RAM, then switches
//   the buffer. RX and TX share the one CSR port with round-robin grant.
//
// Optional build macro: CD_SEQ_TIMEOUT_EN
//   Builds a TX buffer-free wait counter. After TIMEOUT INT_FLAG reads
//   without bit5, the frame is aborted (TX_CTRL=0x10) and tx_timeout pulses.
//   Without the macro, TX_CHK waits indefinitely and tx_timeout is 0.
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   csr_address/read/write/wdata   CSR master port (one access per cycle)
//   csr_readdata                   combinational read data, same cycle as read
//   irq                            controller interrupt, triggers a poll
//   tx_valid/data/last, tx_ready   TX byte stream in
//   rx_valid/data/last, rx_ready   RX byte stream out (1-deep register)
//   evt_valid/evt_flags            pulse + INT_FLAG value on each INT_FLAG read
//   tx_ovf                         pulse: frame longer than TX_MAX
//   tx_timeout                     pulse: TX buffer-free wait aborted
module cd_frame_seq #(
  parameter int POLL_DIV = 1024,
  parameter int TX_MAX   = 256,
  parameter int TIMEOUT  = 65535
) (
  input  logic       clk,
  input  logic       reset,
  output logic [4:0] csr_address,
  output logic       csr_read,
  output logic       csr_write,
  output logic [7:0] csr_writedata,
  input  logic [7:0] csr_readdata,
  input  logic       irq,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_last,
  input  logic       rx_ready,
  output logic       evt_valid,
  output logic [7:0] evt_flags,
  output logic       tx_ovf,
  output logic       tx_timeout
);
  localparam logic [4:0] A_INT = 5'h10, A_RX = 5'h14, A_TX = 5'h15,
                         A_RXC = 5'h16, A_TXC = 5'h17, A_LEN = 5'h19;
  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int TW = $clog2(TX_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_POLL, S_RX_LEN, S_RX_RST, S_RX_DATA, S_RX_DONE,
    S_TX_RST, S_TX_DATA, S_TX_CHK, S_TX_SW, S_TX_ABT
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   poll_cnt_q;
  logic            last_tx_q;     // 1: last grant went to TX
  logic [7:0]      rx_len_q, rx_cnt_q;
  logic [TW-1:0]   tx_cnt_q;      // saturates at TX_MAX
  logic            rx_valid_q, rx_last_q, evt_valid_q, tx_ovf_q;
  logic [7:0]      rx_data_q, evt_flags_q;
  logic            rx_rd, tx_wr;

  // Fetch the next RX byte only when the output register is free this cycle.
  assign rx_rd = (state_q == S_RX_DATA) && (rx_cnt_q != rx_len_q) &&
                 (rx_ready || !rx_valid_q);
  assign tx_wr = (state_q == S_TX_DATA) && tx_valid && (tx_cnt_q < TW'(TX_MAX));

  always_comb begin
    csr_address   = '0;
    csr_read      = 1'b0;
    csr_write     = 1'b0;
    csr_writedata = '0;
    unique case (state_q)
      S_POLL, S_TX_CHK: begin csr_read = 1'b1; csr_address = A_INT; end
      S_RX_LEN:  begin csr_read = 1'b1; csr_address = A_LEN; end
      S_RX_RST:  begin csr_write = 1'b1; csr_address = A_RXC; csr_writedata = 8'h01; end
      S_RX_DATA: begin csr_read = rx_rd; csr_address = rx_rd ? A_RX : 5'h00; end
      S_RX_DONE: begin csr_write = 1'b1; csr_address = A_RXC; csr_writedata = 8'h02; end
      S_TX_RST:  begin csr_write = 1'b1; csr_address = A_TXC; csr_writedata = 8'h01; end
      S_TX_DATA: begin
        csr_write     = tx_wr;
        csr_address   = tx_wr ? A_TX : 5'h00;
        csr_writedata = tx_wr ? tx_data : 8'h00;
      end
      S_TX_SW:   begin csr_write = 1'b1; csr_address = A_TXC; csr_writedata = 8'h02; end
      S_TX_ABT:  begin csr_write = 1'b1; csr_address = A_TXC; csr_writedata = 8'h10; end
      default: ;
    endcase
  end

  assign tx_ready  = (state_q == S_TX_DATA);
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign rx_last   = rx_last_q;
  assign evt_valid = evt_valid_q;
  assign evt_flags = evt_flags_q;
  assign tx_ovf    = tx_ovf_q;

`ifdef CD_SEQ_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT + 1);
  logic [TOW-1:0] to_cnt_q;
  logic           tx_timeout_q;
  assign tx_timeout = tx_timeout_q;
`else
  // Counter not built; TIMEOUT has no effect in this build.
  assign tx_timeout = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      poll_cnt_q  <= '0;
      last_tx_q   <= 1'b0;
      rx_len_q    <= '0;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      rx_valid_q  <= 1'b0;
      rx_last_q   <= 1'b0;
      rx_data_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_flags_q <= '0;
      tx_ovf_q    <= 1'b0;
`ifdef CD_SEQ_TIMEOUT_EN
      to_cnt_q     <= '0;
      tx_timeout_q <= 1'b0;
`endif
    end else begin
      evt_valid_q <= 1'b0;
      tx_ovf_q    <= 1'b0;
`ifdef CD_SEQ_TIMEOUT_EN
      tx_timeout_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (irq || tx_valid || poll_cnt_q == PW'(POLL_DIV - 1)) begin
            state_q    <= S_POLL;
            poll_cnt_q <= '0;
          end else begin
            poll_cnt_q <= poll_cnt_q + 1'b1;
          end
        end
        S_POLL: begin
          evt_valid_q <= 1'b1;
          evt_flags_q <= csr_readdata;
          // RX wins only if TX is idle or TX was served last.
          if (csr_readdata[1] && (!tx_valid || last_tx_q)) begin
            state_q   <= S_RX_LEN;
            last_tx_q <= 1'b0;
          end else if (tx_valid) begin
            state_q   <= S_TX_RST;
            last_tx_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RX_LEN: begin
          rx_len_q <= csr_readdata;
          state_q  <= S_RX_RST;
        end
        S_RX_RST: begin
          rx_cnt_q <= '0;
          state_q  <= (rx_len_q == 8'd0) ? S_RX_DONE : S_RX_DATA;
        end
        S_RX_DATA: begin
          if (rx_rd) begin
            rx_data_q  <= csr_readdata;
            rx_valid_q <= 1'b1;
            rx_last_q  <= (rx_cnt_q + 8'd1 == rx_len_q);
            rx_cnt_q   <= rx_cnt_q + 8'd1;
          end else if (rx_ready) begin
            rx_valid_q <= 1'b0;
            rx_last_q  <= 1'b0;
          end
          if (rx_valid_q && rx_ready && rx_last_q) state_q <= S_RX_DONE;
        end
        S_RX_DONE: state_q <= S_IDLE;
        S_TX_RST: begin
          tx_cnt_q <= '0;
          state_q  <= S_TX_DATA;
        end
        S_TX_DATA: begin
          if (tx_valid) begin
            if (tx_cnt_q < TW'(TX_MAX)) tx_cnt_q <= tx_cnt_q + 1'b1;
            if (tx_last) begin
              // Counter saturated before this byte: frame was over-length.
              tx_ovf_q <= (tx_cnt_q == TW'(TX_MAX));
              state_q  <= S_TX_CHK;
`ifdef CD_SEQ_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
            end
          end
        end
        S_TX_CHK: begin
          evt_valid_q <= 1'b1;
          evt_flags_q <= csr_readdata;
          if (csr_readdata[5]) begin
            state_q <= S_TX_SW;
`ifdef CD_SEQ_TIMEOUT_EN
          end else if (to_cnt_q == TOW'(TIMEOUT - 1)) begin
            state_q      <= S_TX_ABT;
            tx_timeout_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
`endif
          end
        end
        S_TX_SW:  state_q <= S_IDLE;
        S_TX_ABT: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end
endmodule
